// File: rtl/rr_arbiter8_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter8_pkg
//  Description : Shared types and constants for the 8-way round-robin arbiter
//  Revision    : 1.0 - initial release
// ============================================================================
package rr_arbiter8_pkg;

  localparam int N_CLIENTS = 8;
  localparam int IDX_W     = 3;

  typedef logic [N_CLIENTS-1:0] vec_t;
  typedef logic [IDX_W-1:0]     idx_t;

  // Arbiter sequencing: arbitrate, hold the grant, one-cycle turnaround
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter8_if.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter8_if
//  Description : Request/grant bundle between the clients and the arbiter
//  Revision    : 1.0 - initial release
// ============================================================================
interface rr_arbiter8_if;
  import rr_arbiter8_pkg::*;

  vec_t req;
  logic done;
  logic gnt_valid;
  idx_t gnt_idx;
  vec_t gnt;
  logic timeout;

  // Client side: raises requests and releases, observes the grant
  modport master (
    output req,
    output done,
    input  gnt_valid,
    input  gnt_idx,
    input  gnt,
    input  timeout
  );

  // Arbiter side
  modport slave (
    input  req,
    input  done,
    output gnt_valid,
    output gnt_idx,
    output gnt,
    output timeout
  );

endinterface
`default_nettype wire

// File: rtl/rr_arbiter8_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick8
//  Description : Rotating priority picker. The client just after ptr has the
//                highest priority; ptr itself has the lowest, so a sole
//                requester equal to ptr is still found.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick8
  import rr_arbiter8_pkg::*;
(
  input  vec_t req_i,
  input  idx_t ptr_i,
  output logic any_o,
  output idx_t idx_o
);

  logic [2*N_CLIENTS-1:0] w_dbl;
  logic [IDX_W:0]         w_shift;
  vec_t                   w_rot;
  idx_t                   w_off;

  // Rotate so bit 0 is client ptr+1, then find the lowest set bit
  always_comb begin
    w_dbl   = {req_i, req_i};
    w_shift = {1'b0, ptr_i} + {{IDX_W{1'b0}}, 1'b1};
    w_rot   = w_dbl[w_shift +: N_CLIENTS];
    w_off   = '0;
    for (int k = N_CLIENTS - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_off = idx_t'(k);
      end
    end
  end

  // Rotate the offset back into an absolute client index (mod 8 by width)
  assign idx_o = ptr_i + idx_t'(1) + w_off;
  assign any_o = |req_i;

endmodule
`default_nettype wire

// File: rtl/rr_arbiter8.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter8
//  Description : Eight-requester round-robin arbiter with registered grant
//                index, one-cycle turnaround and optional maximum hold time.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter8
  import rr_arbiter8_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16,  // 0 disables the forced release
  parameter int unsigned CNT_W    = 8
)
(
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  rr_arbiter8_if.slave  bus
);

  localparam logic [CNT_W-1:0] C_MAX_HOLD = CNT_W'(MAX_HOLD);
  localparam bit               C_TO_EN    = (MAX_HOLD != 0);

  state_t           state_q;
  idx_t             ptr_q;
  logic             gnt_valid_q;
  idx_t             gnt_idx_q;
  logic             timeout_q;
  logic [CNT_W-1:0] hold_cnt_q;
  logic [CNT_W-1:0] hold_cnt_d;

  logic w_any;
  idx_t w_win;
  logic w_rel_norm;
  logic w_rel_force;

  rr_pick8 u_pick (
    .req_i (bus.req),
    .ptr_i (ptr_q),
    .any_o (w_any),
    .idx_o (w_win)
  );

  // Release conditions; a voluntary release always wins over the timeout
  always_comb begin
    w_rel_norm  = bus.done || !bus.req[gnt_idx_q];
    w_rel_force = C_TO_EN && (hold_cnt_q == C_MAX_HOLD);
    hold_cnt_d  = (hold_cnt_q == {CNT_W{1'b1}}) ? hold_cnt_q
                                                : hold_cnt_q + CNT_W'(1);
  end

  // Sequencing FSM with all outputs registered
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= idx_t'(N_CLIENTS - 1);
      gnt_valid_q <= 1'b0;
      gnt_idx_q   <= '0;
      timeout_q   <= 1'b0;
      hold_cnt_q  <= '0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (w_any) begin
            state_q     <= GRANT;
            gnt_idx_q   <= w_win;
            gnt_valid_q <= 1'b1;
            hold_cnt_q  <= CNT_W'(1);
          end
        end
        GRANT: begin
          if (w_rel_norm || w_rel_force) begin
            ptr_q       <= gnt_idx_q;
            gnt_valid_q <= 1'b0;
            state_q     <= GAP;
            timeout_q   <= !w_rel_norm;
          end else begin
            hold_cnt_q  <= hold_cnt_d;
          end
        end
        GAP: begin
          gnt_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: begin
          gnt_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign bus.gnt_valid = gnt_valid_q;
  assign bus.gnt_idx   = gnt_idx_q;
  assign bus.timeout   = timeout_q;
  assign bus.gnt       = gnt_valid_q ? (vec_t'(1) << gnt_idx_q) : '0;

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter8.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rr_arbiter8
//  Description : Scoreboard bench for rr_arbiter8. Two instances: A with the
//                default hold limit of 16, B with a hold limit of 4.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_arbiter8;
  import rr_arbiter8_pkg::*;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;

  always #5 sys_clk = ~sys_clk;

  rr_arbiter8_if bus_a();
  rr_arbiter8_if bus_b();

  rr_arbiter8 #(.MAX_HOLD(16), .CNT_W(8)) dut_a (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus_a)
  );

  rr_arbiter8 #(.MAX_HOLD(4), .CNT_W(8)) dut_b (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus_b)
  );

  // One expected grant: owner, length in cycles, timeout pulse after it,
  // idle cycles before it (-1 = not checked)
  typedef struct {
    int idx;
    int dur;
    bit to;
    int gap;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic void check(string name, int act, int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endfunction

  function automatic logic get_v(bit sel);
    return sel ? bus_b.gnt_valid : bus_a.gnt_valid;
  endfunction
  function automatic int get_idx(bit sel);
    return sel ? int'(bus_b.gnt_idx) : int'(bus_a.gnt_idx);
  endfunction
  function automatic int get_gnt(bit sel);
    return sel ? int'(bus_b.gnt) : int'(bus_a.gnt);
  endfunction
  function automatic logic get_to(bit sel);
    return sel ? bus_b.timeout : bus_a.timeout;
  endfunction

  task automatic set_req(bit sel, logic [7:0] v);
    if (sel) bus_b.req = v; else bus_a.req = v;
  endtask
  task automatic set_done(bit sel, logic v);
    if (sel) bus_b.done = v; else bus_a.done = v;
  endtask
  task automatic push(bit sel, int idx, int dur, bit to, int gap);
    exp_t e;
    e.idx = idx; e.dur = dur; e.to = to; e.gap = gap;
    if (sel) q_b.push_back(e); else q_a.push_back(e);
  endtask

  // Monitor: sampled on the falling edge, compares each completed grant
  task automatic monitor(bit sel, string tag);
    logic pv = 1'b0;
    int   dur = 0, gap = 0, cur_idx = 0, mgap = -1;
    bit   seen = 1'b0;
    logic v, to;
    int   idx, g;
    exp_t e;
    forever begin
      @(negedge sys_clk);
      if (!sys_rst_n) begin
        pv = 1'b0; dur = 0; gap = 0; seen = 1'b0;
        continue;
      end
      v   = get_v(sel);
      idx = get_idx(sel);
      g   = get_gnt(sel);
      to  = get_to(sel);
      check({tag, " gnt vector"}, g, v ? (1 << idx) : 0);
      if (!v && pv) begin
        if ((sel ? q_b.size() : q_a.size()) == 0) begin
          checks++; failures++;
          $display("FAIL %s unexpected grant: got idx %0d expected none", tag, cur_idx);
        end else begin
          e = sel ? q_b.pop_front() : q_a.pop_front();
          check({tag, " grant idx"}, cur_idx, e.idx);
          check({tag, " grant length"}, dur, e.dur);
          check({tag, " timeout after grant"}, int'(to), int'(e.to));
          if (e.gap >= 0) check({tag, " idle gap"}, mgap, e.gap);
        end
      end else if (to) begin
        checks++; failures++;
        $display("FAIL %s stray timeout: got 1 expected 0", tag);
      end
      if (v && !pv) begin
        cur_idx = idx; dur = 1; mgap = seen ? gap : -1; seen = 1'b1; gap = 0;
      end else if (v) begin
        dur++;
      end else begin
        gap++;
      end
      pv = v;
    end
  endtask

  initial monitor(1'b0, "A");
  initial monitor(1'b1, "B");

  // Wait for a grant, hold it n cycles, then release by done or by req change
  task automatic serve(bit sel, int n, bit use_done, logic [7:0] new_req, string name);
    bit got = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge sys_clk); #1;
      if (get_v(sel)) begin got = 1'b1; break; end
    end
    if (!got) begin
      checks++; failures++;
      $display("FAIL %s: gnt_valid got 0 expected 1 within 30 cycles", name);
      return;
    end
    repeat (n - 1) begin @(posedge sys_clk); #1; end
    if (use_done) set_done(sel, 1'b1); else set_req(sel, new_req);
    @(posedge sys_clk); #1;
    set_done(sel, 1'b0);
  endtask

  task automatic wait_release(bit sel, string name);
    bit seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge sys_clk); #1;
      if (get_v(sel)) seen = 1'b1;
      else if (seen) return;
    end
    checks++; failures++;
    $display("FAIL %s: release got none expected within 40 cycles", name);
  endtask

  task automatic tick(int n);
    repeat (n) begin @(posedge sys_clk); #1; end
  endtask

  task automatic do_reset();
    @(posedge sys_clk); #1;
    sys_rst_n = 1'b0;
    set_req(0, 8'h00); set_req(1, 8'h00);
    set_done(0, 1'b0); set_done(1, 1'b0);
    tick(2);
    sys_rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    bus_a.req = 8'h00; bus_a.done = 1'b0;
    bus_b.req = 8'h00; bus_b.done = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;

    // Quiet after reset with no requests
    check("reset gnt_idx", int'(bus_a.gnt_idx), 0);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("idle gnt_valid A", int'(bus_a.gnt_valid), 0);
      check("idle gnt A", int'(bus_a.gnt), 0);
      check("idle timeout A", int'(bus_a.timeout), 0);
      check("idle gnt_valid B", int'(bus_b.gnt_valid), 0);
    end

    // Sole requester 3: done on 5th cycle, then re-granted, released by req drop
    push(0, 3, 5, 1'b0, -1);
    push(0, 3, 2, 1'b0, 2);
    set_req(0, 8'h08);
    serve(0, 5, 1'b1, 8'h08, "t2 first grant");
    serve(0, 2, 1'b0, 8'h00, "t2 regrant");
    tick(3);

    // Clients 0 and 7 alternate from a fresh pointer
    do_reset();
    push(0, 0, 2, 1'b0, -1);
    push(0, 7, 2, 1'b0, 2);
    push(0, 0, 2, 1'b0, 2);
    push(0, 7, 2, 1'b0, 2);
    set_req(0, 8'h81);
    serve(0, 2, 1'b1, 8'h81, "t3 grant 1");
    serve(0, 2, 1'b1, 8'h81, "t3 grant 2");
    serve(0, 2, 1'b1, 8'h81, "t3 grant 3");
    serve(0, 2, 1'b1, 8'h81, "t3 grant 4");
    set_req(0, 8'h00);
    tick(3);

    // Hold limit 4: forced release with timeout, then voluntary re-grant
    push(1, 2, 4, 1'b1, -1);
    push(1, 2, 2, 1'b0, 2);
    set_req(1, 8'h04);
    wait_release(1, "t4 forced release");
    serve(1, 2, 1'b1, 8'h04, "t4 regrant");
    set_req(1, 8'h00);
    tick(3);

    // done coinciding with the hold limit is a normal release
    push(1, 2, 4, 1'b0, -1);
    set_req(1, 8'h04);
    serve(1, 4, 1'b1, 8'h04, "t5 done at limit");
    set_req(1, 8'h00);
    tick(3);

    // Owner 4 drops its request; client 5 follows
    push(0, 4, 3, 1'b0, -1);
    push(0, 5, 2, 1'b0, 2);
    set_req(0, 8'h30);
    serve(0, 3, 1'b0, 8'h20, "t6 owner drop");
    serve(0, 2, 1'b0, 8'h00, "t6 next owner");
    tick(3);

    // Asynchronous reset in the middle of a grant
    set_req(0, 8'h02);
    tick(1);
    check("t7 grant before reset", int'(bus_a.gnt_valid), 1);
    #2 sys_rst_n = 1'b0;
    #1;
    check("t7 async gnt_valid", int'(bus_a.gnt_valid), 0);
    check("t7 async gnt", int'(bus_a.gnt), 0);
    check("t7 async gnt_idx", int'(bus_a.gnt_idx), 0);
    check("t7 async timeout", int'(bus_a.timeout), 0);
    set_req(0, 8'h00);
    @(posedge sys_clk); #1;
    sys_rst_n = 1'b1;
    tick(5);

    check("scoreboard A drained", q_a.size(), 0);
    check("scoreboard B drained", q_b.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rr_arbiter8.md
Name: rr_arbiter8

Overview:
- Eight-requester round-robin arbiter that shares one resource selected by a 3-bit index.
- Drives the one-hot select decoder with a registered grant index and owns the sequencing: grant, hold, release, turnaround.
- Sits between up to eight client blocks and the shared resource.
- Enforces a maximum hold time so no client can starve the others.

Parameters:
MAX_HOLD, 16, maximum consecutive grant cycles per owner; 0 = unlimited (timeout disabled)
CNT_W, 8, hold counter width; must satisfy MAX_HOLD < 2**CNT_W

Ports:
sys_clk  input  1  system clock, all state on rising edge
sys_rst_n  input  1  asynchronous active-low reset
req  input  8  request vector, bit i = client i wants the resource; level-held by client
done  input  1  current owner releases the resource (sampled only in GRANT)
gnt_valid  output  1  a grant is active this cycle
gnt_idx  output  3  index of current owner; drives decoder select
gnt  output  8  one-hot grant = (1 << gnt_idx) when gnt_valid, else 8'h00
timeout  output  1  one-cycle pulse: grant forcibly revoked by MAX_HOLD

Behaviour:
- Clock and reset: one clock, sys_clk; reset sys_rst_n is asynchronous, active-low.
- Reset (async, immediate, also mid-grant):
  - state=IDLE, gnt_valid=0, gnt_idx=0, gnt=8'h00, timeout=0, hold_cnt=0.
  - Priority pointer ptr=7, so client 0 has highest priority first.
- All outputs are registered. gnt is derived combinationally from the registered gnt_valid/gnt_idx; no latches, and every branch assigns a default.
- State IDLE:
  - If req != 0 at edge N: winner = first set bit scanning ptr+1, ptr+2, ... modulo 8.
  - At edge N the block enters GRANT with gnt_idx=winner, gnt_valid=1, hold_cnt=1.
  - Grant is visible in cycle N+1, i.e. one-cycle latency from request to grant.
  - If req == 0, stay in IDLE.
- State GRANT, evaluated each edge:
  - (a) done=1, or req[gnt_idx]=0: normal release.
  - (b) otherwise, MAX_HOLD != 0 and hold_cnt == MAX_HOLD: forced release; timeout=1 for exactly the next cycle.
  - (c) otherwise stay and increment hold_cnt.
- On any release:
  - ptr <= gnt_idx.
  - gnt_valid=0 and state=GAP.
- State GAP (one turnaround cycle):
  - gnt_valid=0.
  - Returns to IDLE unconditionally; IDLE arbitrates at its next edge.
  - The resource is idle for at least 2 cycles between owners and two owners never overlap.
- Simultaneous events:
  - done=1 in the cycle where hold_cnt==MAX_HOLD: normal release, timeout stays 0.
  - Requests from non-owners during GRANT/GAP are ignored until IDLE.
- Grant duration: with MAX_HOLD=M, a grant lasts at most M cycles.
- Wrap-around: the pointer scan wraps 7→0. A sole requester equal to ptr is still granted (full 8-position scan).
- hold_cnt saturates; it never wraps while MAX_HOLD=0.
- gnt_idx retains its last value while gnt_valid=0; only gnt is forced to zero.

Decomposition:
- Shared package:
  - State encoding constants: IDLE=2'd0, GRANT=2'd1, GAP=2'd2.
  - Client count constant N_CLIENTS=8 and index width 3.
- One natural sub-module: rr_pick8.
  - Combinational: inputs req[7:0] and ptr[2:0].
  - Outputs any and idx[2:0]: rotate, priority-encode, rotate back.
- The top level holds the FSM, hold counter, pointer and output registers.

Test Plan:
- Reset release with req=8'h00 → gnt_valid=0, gnt=8'h00, timeout=0 for 10 cycles; assert sys_rst_n low mid-cycle → outputs clear without waiting for a clock edge.
- req=8'h08 held, done pulsed on the 5th grant cycle → gnt=8'h08 from cycle after request, lasts 5 cycles, then GAP, then re-granted to client 3 (only requester).
- req=8'h81 held, done after 2 grant cycles each time → grant order 0,7,0,7 with 2 idle cycles between each.
- MAX_HOLD=4, req=8'h04 held, done=0 → gnt=8'h04 for exactly 4 cycles, timeout=1 in the following cycle only, later re-grant to client 2.
- MAX_HOLD=4, done=1 in the 4th grant cycle → release with timeout=0.
- Owner drops req[idx] mid-grant with req=8'h30 → immediate release; next grant goes to client 5 if owner was 4.
